// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the EXE stage.
// One op in flight: DATA_W shift-add or restoring-divide steps, then one
// sign-fix cycle that commits the result to HI/LO.
module muldiv_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    input  logic              flush,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] hilo_wdata,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    // MUL: {partial product, remaining multiplier bits}
    logic [2*DATA_W-1:0] acc_q, acc_d;
    // Multiplicand magnitude for MUL, divisor magnitude for DIV
    logic [DATA_W-1:0]   oper_q, oper_d;
    // DIV: partial remainder and dividend/quotient shift register
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic                neg_q, neg_d;     // negate product/quotient
    logic                rsgn_q, rsgn_d;   // remainder takes dividend sign
    logic                is_div_q, is_div_d;
    logic                bz_q, bz_d;       // divisor was zero
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic                is_signed;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift, div_trial;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    // Operand magnitudes and per-step datapath arithmetic
    assign is_signed = ~op[0];
    assign a_mag     = (is_signed && opa[DATA_W-1]) ? -opa : opa;
    assign b_mag     = (is_signed && opb[DATA_W-1]) ? -opb : opb;
    assign mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, oper_q} : '0);
    assign div_shift = {rem_q, quo_q[DATA_W-1]};
    assign div_trial = div_shift - {1'b0, oper_q};
    assign prod_fix  = neg_q ? -acc_q : acc_q;
    // Divide-by-zero leaves the dividend in rem_q, so the sign fix restores raw opa
    assign quo_fix   = bz_q ? '1 : (neg_q ? -quo_q : quo_q);
    assign rem_fix   = rsgn_q ? -rem_q : rem_q;

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // Next-state, iteration and HI/LO write logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        oper_d   = oper_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        neg_d    = neg_q;
        rsgn_d   = rsgn_q;
        is_div_d = is_div_q;
        bz_d     = bz_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (hi_we) hi_d = hilo_wdata;
        if (lo_we) lo_d = hilo_wdata;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    neg_d    = is_signed & (opa[DATA_W-1] ^ opb[DATA_W-1]);
                    rsgn_d   = is_signed & opa[DATA_W-1];
                    is_div_d = op[1];
                    bz_d     = op[1] & (opb == '0);
                    dbz_d    = 1'b0;
                    cnt_d    = CntW'(DATA_W);
                    if (op[1]) begin
                        state_d = StDiv;
                        oper_d  = b_mag;
                        rem_d   = '0;
                        quo_d   = a_mag;
                        acc_d   = '0;
                    end else begin
                        state_d = StMul;
                        oper_d  = a_mag;
                        acc_d   = {{DATA_W{1'b0}}, b_mag};
                    end
                end
            end
            StMul: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = {mul_sum, acc_q[DATA_W-1:1]};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) state_d = StFix;
                end
            end
            StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    // Restoring step: keep the trial difference only if it did not go negative
                    if (div_trial[DATA_W]) begin
                        rem_d = div_shift[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end else begin
                        rem_d = div_trial[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) state_d = StFix;
                end
            end
            StFix: begin
                // Result is committed here regardless of flush; it overrides MTHI/MTLO
                if (is_div_q) begin
                    hi_d  = rem_fix;
                    lo_d  = quo_fix;
                    dbz_d = bz_q;
                end else begin
                    hi_d = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d = prod_fix[DATA_W-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            oper_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            neg_q    <= 1'b0;
            rsgn_q   <= 1'b0;
            is_div_q <= 1'b0;
            bz_q     <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            oper_q   <= oper_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            neg_q    <= neg_d;
            rsgn_q   <= rsgn_d;
            is_div_q <= is_div_d;
            bz_q     <= bz_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hilo_wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .opa        (opa),
        .opb        (opb),
        .flush      (flush),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .hilo_wdata (hilo_wdata),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model state and the pending op's expected result
    logic [31:0] mhi, mlo, exp_hi, exp_lo;
    logic        mdbz, exp_dbz;
    int          t_acc;
    int          nbusy;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rhi, output logic [31:0] rlo,
                                   output logic rdbz);
        longint          sp;
        longint unsigned up;
        rdbz = 1'b0;
        rhi  = '0;
        rlo  = '0;
        case (o)
            2'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {rhi, rlo} = sp;
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                {rhi, rlo} = up;
            end
            2'd2: begin
                if (b == 32'd0) begin
                    rlo = 32'hFFFF_FFFF; rhi = a; rdbz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    rlo = 32'h8000_0000; rhi = 32'd0;
                end else begin
                    rlo = 32'($signed(a) / $signed(b));
                    rhi = 32'($signed(a) % $signed(b));
                end
            end
            default: begin
                if (b == 32'd0) begin
                    rlo = 32'hFFFF_FFFF; rhi = a; rdbz = 1'b1;
                end else begin
                    rlo = a / b;
                    rhi = a % b;
                end
            end
        endcase
    endfunction

    // Call at a negedge; returns at the negedge right after the accept edge
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0;
        t_acc = cyc;
        ref_op(o, a, b, exp_hi, exp_lo, exp_dbz);
        mdbz = 1'b0;
        check_val("accept_busy", {63'd0, busy}, 64'd1);
    endtask

    // Returns at the negedge of the done cycle (or after a timeout)
    task automatic wait_done(input string tag);
        nbusy = 0;
        while (!done && (cyc - t_acc) < 100) begin
            if (busy) nbusy++;
            @(negedge clk);
        end
        check_val({tag, "_done"}, {63'd0, done}, 64'd1);
        if (done) begin
            check_val({tag, "_latency"}, 64'(cyc - t_acc), 64'd33);
            check_val({tag, "_busy_off"}, {63'd0, busy}, 64'd0);
            check_val({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
            check_val({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
            check_val({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
            mhi  = exp_hi;
            mlo  = exp_lo;
            mdbz = exp_dbz;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        @(negedge clk);
        launch(o, a, b);
        wait_done(tag);
        @(negedge clk);
        check_val({tag, "_pulse"}, {63'd0, done}, 64'd0);
    endtask

    logic [1:0]  r_o;
    logic [31:0] r_a, r_b;
    int          sel;

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; flush = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
        mhi = '0; mlo = '0; mdbz = 1'b0; exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
        t_acc = 0; nbusy = 0;
        #2;
        check_val("rst_hi", {32'd0, hi}, 64'd0);
        check_val("rst_lo", {32'd0, lo}, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner cases
        @(negedge clk);
        launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max");
        check_val("multu_busy_cycles", 64'(nbusy), 64'd33);
        @(negedge clk);
        run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, "mult_neg");
        run_op(2'd3, 32'd100, 32'd7, "divu");
        run_op(2'd2, 32'hFFFF_FF9C, 32'd7, "div_neg");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'd3, 32'd5, 32'd0, "divu_zero");
        run_op(2'd1, 32'd2, 32'd3, "multu_clear");
        run_op(2'd2, 32'hFFFF_FFF6, 32'd0, "div_zero_neg");

        // Flush on the 10th busy cycle
        @(negedge clk);
        launch(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_val("flush_busy", {63'd0, busy}, 64'd0);
        check_val("flush_done", {63'd0, done}, 64'd0);
        check_val("flush_hi", {32'd0, hi}, {32'd0, mhi});
        check_val("flush_lo", {32'd0, lo}, {32'd0, mlo});
        repeat (40) begin
            @(negedge clk);
            if (done) check_val("flush_no_done", {63'd0, done}, 64'd0);
        end
        check_val("flush_dbz", {63'd0, div_by_zero}, {63'd0, mdbz});

        // Flush in idle suppresses start
        start = 1'b1; flush = 1'b1; op = 2'd1; opa = 32'd9; opb = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check_val("idle_flush_busy", {63'd0, busy}, 64'd0);

        // Back-to-back: launch again on the done cycle
        launch(2'd0, 32'hFFFF_FF00, 32'h0000_0100);
        wait_done("b2b_first");
        launch(2'd3, 32'hDEAD_BEEF, 32'h0000_1234);
        wait_done("b2b_second");
        @(negedge clk);

        // Start while busy is ignored
        launch(2'd3, 32'd1000, 32'd9);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd0; opa = 32'h7777_7777; opb = 32'h3333_3333;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        @(negedge clk);

        // MTHI/MTLO in idle
        hi_we = 1'b1; hilo_wdata = 32'hA5A5_0001;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; hilo_wdata = 32'h5A5A_0002;
        check_val("mthi", {32'd0, hi}, 64'hA5A5_0001);
        @(negedge clk);
        lo_we = 1'b0;
        check_val("mtlo", {32'd0, lo}, 64'h5A5A_0002);
        mhi = 32'hA5A5_0001; mlo = 32'h5A5A_0002;

        // hi_we on the FIX edge loses to the result
        launch(2'd1, 32'd6, 32'd7);
        repeat (32) @(negedge clk);
        hi_we = 1'b1; hilo_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        hi_we = 1'b0;
        check_val("fix_we_done", {63'd0, done}, 64'd1);
        check_val("fix_we_hi", {32'd0, hi}, {32'd0, exp_hi});
        check_val("fix_we_lo", {32'd0, lo}, {32'd0, exp_lo});

        // Random operations
        for (int i = 0; i < 40; i++) begin
            r_o = 2'($urandom_range(0, 3));
            r_a = $urandom;
            r_b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) r_b = 32'd0;
            if (sel == 1) r_b = $urandom_range(1, 15);
            if (sel == 2) r_a = $urandom_range(0, 255);
            if (sel == 3) r_b = 32'hFFFF_FFFF;
            run_op(r_o, r_a, r_b, $sformatf("rand%0d_op%0d", i, r_o));
        end

        // Async reset mid-DIV
        @(negedge clk);
        launch(2'd2, 32'h0BAD_F00D, 32'd13);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("arst_hi", {32'd0, hi}, 64'd0);
        check_val("arst_lo", {32'd0, lo}, 64'd0);
        check_val("arst_busy", {63'd0, busy}, 64'd0);
        check_val("arst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mhi = '0; mlo = '0; mdbz = 1'b0;
        run_op(2'd0, 32'hFFFF_FFFF, 32'd5, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
